// File: rtl/rec2pol_pkg.sv
// Shared widths, angle constants and FSM encoding for the rec2pol scheduler.
package rec2pol_pkg;
    localparam int XW      = 13;
    localparam int AW      = 19;
    localparam int FRAC    = 10;
    localparam int ANG_180 = 180 << FRAC;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt,
    output logic            vld
);
    always_comb begin
        gnt = ptr;
        vld = 1'b0;
        // Walk farthest-first so the nearest set request wins the last assignment
        for (int i = NREQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                gnt = PW'(idx);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rec2pol_sched.sv
// Time-shares one rec2pol_2step CORDIC core among NREQ requesters, round-robin.
// Define REC2POL_QUAD_EN for full-circle support (x<0 pre-negated, +/-180 deg fix-up).
module rec2pol_sched #(
    parameter int NREQ    = 4,
    parameter int XW      = rec2pol_pkg::XW,
    parameter int AW      = rec2pol_pkg::AW,
    parameter int LATENCY = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*XW-1:0] x_in,
    input  logic [NREQ*XW-1:0] y_in,
    output logic [NREQ-1:0]    done,
    output logic [AW-1:0]      angle_out,
    output logic [2:0]         ch_out,
    output logic               busy,
    output logic               r2p_start,
    output logic               r2p_enable,
    output logic [XW-1:0]      r2p_x,
    output logic [XW-1:0]      r2p_y,
    input  logic [AW-1:0]      r2p_angle
);
    import rec2pol_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state;
    logic [PW-1:0] ptr, gnt, pick;
    logic          pick_vld;
    logic [CW-1:0] cnt;
    logic [XW-1:0] xs, ys, xc, yc;
    logic [AW-1:0] ang_post;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (pick),
        .vld (pick_vld)
    );

    assign xs   = x_in[int'(pick)*XW +: XW];
    assign ys   = y_in[int'(pick)*XW +: XW];
    assign busy = (state != IDLE);

`ifdef REC2POL_QUAD_EN
    localparam logic [AW-1:0] A180 = AW'(ANG_180);

    logic flip, flip_q, ypos_q;

    // -(-2^(XW-1)) has no positive twin; clamp to the largest positive value
    function automatic logic [XW-1:0] sat_neg(input logic [XW-1:0] v);
        if (v == {1'b1, {(XW-1){1'b0}}}) return {1'b0, {(XW-1){1'b1}}};
        return -v;
    endfunction

    assign flip     = xs[XW-1];
    assign xc       = flip ? sat_neg(xs) : xs;
    assign yc       = flip ? sat_neg(ys) : ys;
    assign ang_post = !flip_q ? r2p_angle : (ypos_q ? r2p_angle + A180 : r2p_angle - A180);
`else
    assign xc       = xs;
    assign yc       = ys;
    assign ang_post = r2p_angle;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            done       <= '0;
            angle_out  <= '0;
            ch_out     <= '0;
            r2p_start  <= 1'b0;
            r2p_enable <= 1'b0;
            r2p_x      <= '0;
            r2p_y      <= '0;
`ifdef REC2POL_QUAD_EN
            flip_q     <= 1'b0;
            ypos_q     <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: if (pick_vld) begin
                    gnt   <= pick;
                    r2p_x <= xc;
                    r2p_y <= yc;
`ifdef REC2POL_QUAD_EN
                    flip_q <= flip;
                    ypos_q <= !ys[XW-1];
`endif
                    state <= ISSUE;
                end
                ISSUE: begin
                    r2p_start  <= 1'b1;
                    r2p_enable <= 1'b1;
                    cnt        <= CW'(LATENCY - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    r2p_start  <= 1'b0;
                    r2p_enable <= 1'b1;
                    if (cnt == '0) state <= CAPT;
                    else           cnt   <= cnt - 1'b1;
                end
                CAPT: begin
                    r2p_enable <= 1'b0;
                    angle_out  <= ang_post;
                    ch_out     <= 3'(gnt);
                    state      <= DONE;
                end
                DONE: begin
                    done[gnt] <= 1'b1;
                    ptr       <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rec2pol_sched.sv
// Randomized bench for rec2pol_sched with a behavioural core stand-in and a timeline reference model.
module tb_rec2pol_sched;
    localparam int NREQ = 4, XW = 13, AW = 19, LATENCY = 8;
    localparam int A180 = 184320;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] x_in, y_in;
    logic [NREQ-1:0]    done;
    logic [AW-1:0]      angle_out;
    logic [2:0]         ch_out;
    logic               busy, r2p_start, r2p_enable;
    logic [XW-1:0]      r2p_x, r2p_y;
    logic [AW-1:0]      r2p_angle;

    rec2pol_sched #(.NREQ(NREQ), .XW(XW), .AW(AW), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
        .done(done), .angle_out(angle_out), .ch_out(ch_out), .busy(busy),
        .r2p_start(r2p_start), .r2p_enable(r2p_enable), .r2p_x(r2p_x),
        .r2p_y(r2p_y), .r2p_angle(r2p_angle)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int cyc = 0;
    bit started = 0;

    function automatic int sx(input logic [XW-1:0] v);
        logic signed [XW-1:0] s;
        s = v;
        return s;
    endfunction

    function automatic int sa(input logic [AW-1:0] v);
        logic signed [AW-1:0] s;
        s = v;
        return s;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Ideal core: atan2 in degrees with 10 fractional bits
    function automatic int ref_ang(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 1024.0;
        return $rtoi(a);
    endfunction

    function automatic int neg_sat(input int v);
        return (v == -(1 << (XW-1))) ? (1 << (XW-1)) - 1 : -v;
    endfunction

    function automatic bit quad();
`ifdef REC2POL_QUAD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_ang(input int x, input int y);
        if (quad() && x < 0)
            return ref_ang(neg_sat(x), neg_sat(y)) + ((y >= 0) ? A180 : -A180);
        return ref_ang(x, y);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
        end
    endtask

    // Core stand-in: angle valid only on the LATENCY-th enabled clock after start
    int cx = 0, cy = 0, ccnt = 0;
    always @(posedge clock) begin
        if (!reset) ccnt <= 0;
        else if (r2p_start && r2p_enable) begin
            ccnt <= 1; cx <= sx(r2p_x); cy <= sx(r2p_y);
        end else if (r2p_enable && ccnt != 0) ccnt <= ccnt + 1;
    end
    always_comb r2p_angle = (ccnt == LATENCY) ? AW'(ref_ang(cx, cy)) : AW'(87381);

    // Reference timeline: a grant at edge g makes busy g..g+10, start g+1,
    // enable g+1..g+9, angle/ch update g+10, done g+11, next grant >= g+12
    bit act = 0;
    int g_cyc = 0, g_ch = 0, g_ang = 0, ptr = 0;
    int m_ang = 0, m_ch = 0, m_rx = 0, m_ry = 0;
    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            started = 1; act = 0; ptr = 0;
            m_ang = 0; m_ch = 0; m_rx = 0; m_ry = 0;
        end else begin
            if (act && cyc - g_cyc == 10) begin m_ang = g_ang; m_ch = g_ch; end
            if (act && cyc - g_cyc == 11) ptr = (g_ch + 1) % NREQ;
            if ((!act || cyc - g_cyc >= 12) && req != 0) begin
                int c, tx, ty;
                c = -1;
                for (int k = 0; k < NREQ; k++)
                    if (c < 0 && req[(ptr + k) % NREQ]) c = (ptr + k) % NREQ;
                tx = sx(x_in[c*XW +: XW]);
                ty = sx(y_in[c*XW +: XW]);
                g_ch = c; g_cyc = cyc; act = 1;
                g_ang = exp_ang(tx, ty);
                m_rx = (quad() && tx < 0) ? neg_sat(tx) : tx;
                m_ry = (quad() && tx < 0) ? neg_sat(ty) : ty;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            int d;
            d = cyc - g_cyc;
            chk("busy", int'(busy), int'(act && d >= 0 && d <= 10));
            chk("start", int'(r2p_start), int'(act && d == 1));
            chk("enable", int'(r2p_enable), int'(act && d >= 1 && d <= 9));
            chk("done", int'(done), (act && d == 11) ? (1 << g_ch) : 0);
            chk("angle_out", sa(angle_out), m_ang);
            chk("ch_out", int'(ch_out), m_ch);
            chk("r2p_x", sx(r2p_x), m_rx);
            chk("r2p_y", sx(r2p_y), m_ry);
        end
    end

    int starts[$];
    always @(negedge clock) if (started && r2p_start) starts.push_back(cyc);

    int ord[16], ord_cyc[16];

    // Gathers the next n done pulses (channel and cycle); returns on the pulse cycle
    task automatic collect(input int n);
        int got = 0, budget = 0;
        while (got < n && budget < n * 20 + 40) begin
            @(negedge clock);
            budget++;
            if (done != 0) begin
                for (int k = 0; k < NREQ; k++) if (done[k]) ord[got] = k;
                ord_cyc[got] = cyc;
                got++;
            end
        end
        if (got < n) chk("collect_timeout", got, n);
    endtask

    task automatic set_vec(input int ch, input int x, input int y);
        x_in[ch*XW +: XW] = XW'(x);
        y_in[ch*XW +: XW] = XW'(y);
    endtask

    task automatic serve_one(input int ch);
        req = '0; req[ch] = 1'b1;
        collect(1);
        req = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, a;
        reset = 1'b0; req = '0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_start", int'(r2p_start), 0);
        chk("rst_angle", sa(angle_out), 0);
        reset = 1'b1;
        @(negedge clock);

        // Single request latency and angle
        set_vec(0, 123, 456);
        req = 4'b0001; s = cyc + 1;
        collect(1);
        req = '0;
        chk("t1_latency", ord_cyc[0] - s, 11);
        chk("t1_ch", int'(ch_out), 0);
        chk("t1_angle_tol", int'(iabs(sa(angle_out) - 76696) <= 512), 1);
        repeat (2) @(negedge clock);

        // All four held: strict rotation, 12-clock start spacing
        serve_one(3);
        for (int k = 0; k < NREQ; k++) set_vec(k, 100 * (k + 1), 50 - 40 * k);
        starts.delete();
        req = 4'b1111;
        collect(8);
        req = '0;
        for (int i = 0; i < 8; i++) chk("t2_order", ord[i], i % NREQ);
        chk("t2_nstart", starts.size(), 8);
        for (int i = 1; i < starts.size(); i++) chk("t2_gap", starts[i] - starts[i-1], 12);
        repeat (2) @(negedge clock);

        // Pointer at 2, req 0011: ch0 wraps ahead of ch1
        serve_one(1);
        req = 4'b0011;
        collect(2);
        req = '0;
        chk("t3_first", ord[0], 0);
        chk("t3_second", ord[1], 1);
        repeat (2) @(negedge clock);

        // Reset during WAIT discards the conversion
        set_vec(0, 300, 200);
        req = 4'b0001;
        repeat (4) @(negedge clock);
        reset = 1'b0; req = '0;
        @(negedge clock);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_enable", int'(r2p_enable), 0);
        chk("t4_angle", sa(angle_out), 0);
        reset = 1'b1;
        set_vec(1, 700, -900);
        req = 4'b0010;
        collect(1);
        req = '0;
        chk("t4_regrant", ord[0], 1);
        repeat (2) @(negedge clock);

        // Request dropped two clocks after grant still completes on time
        set_vec(1, 2000, 1500);
        req = 4'b0010; s = cyc + 1;
        repeat (3) @(negedge clock);
        req = '0;
        collect(1);
        chk("t5_ch", ord[0], 1);
        chk("t5_latency", ord_cyc[0] - s, 11);
        repeat (2) @(negedge clock);

`ifdef REC2POL_QUAD_EN
        set_vec(0, -100, -100);
        serve_one(0);
        a = sa(angle_out);
        chk("q_m135", int'(iabs(a + 138240) <= 512), 1);
        set_vec(0, -100, 0);
        serve_one(0);
        a = sa(angle_out);
        chk("q_180", int'(iabs(a - A180) <= 512), 1);
        set_vec(0, -4096, 1);
        serve_one(0);
        a = sa(angle_out);
        chk("q_sat", int'(iabs(a - A180) <= 512), 1);
`endif

        // Random traffic, vectors churning every cycle, occasional reset
        for (int i = 0; i < 1500; i++) begin
            int ch, xr, yr;
            @(negedge clock);
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < NREQ; k++) if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
            ch = int'($urandom_range(0, NREQ - 1));
            xr = quad() ? int'($urandom_range(0, 8191)) - 4096 : int'($urandom_range(0, 4095));
            yr = int'($urandom_range(0, 8191)) - 4096;
            set_vec(ch, xr, yr);
        end
        @(negedge clock);
        reset = 1'b1; req = '0;
        repeat (20) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
